// File: rtl/usbh_pkg.sv
// Shared definitions for the USB full-speed host token path: PID bytes,
// token transmitter state encoding and the token CRC5 seed.
package usbh_pkg;

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SOF   = 8'hA5;
    localparam logic [7:0] PID_SETUP = 8'h2D;

    localparam logic [4:0] CRC5_SEED = 5'h1F;

    typedef enum logic [2:0] {
        TOK_IDLE,
        TOK_PID,
        TOK_TOK1,
        TOK_TOK2,
        TOK_GAP
    } token_state_e;

    // A PID byte carries its own check nibble: the upper half is the
    // complement of the lower half.
    function automatic logic pidCheckOk(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

endpackage

// File: rtl/usbh_crc5.sv
// Combinational USB token CRC5 (x^5 + x^2 + 1) over an 11-bit field,
// processed LSB first in reflected form so crc_o[0] is the first CRC bit on the wire.
module usbh_crc5 (
    input  logic [4:0]  crc_i,
    input  logic [10:0] data_i,
    output logic [4:0]  crc_o
);

    logic [4:0] crcAcc;

    always_comb begin
        crcAcc = crc_i;
        for (int i = 0; i < 11; i++) begin
            if (crcAcc[0] ^ data_i[i]) begin
                crcAcc = (crcAcc >> 1) ^ 5'h14;
            end else begin
                crcAcc = crcAcc >> 1;
            end
        end
        crc_o = crcAcc;
    end

endmodule

// File: rtl/usbh_token_tx.sv
// Token packet transmitter: PID, token low byte, then {crc5, token high bits} onto UTMI.
// Define USBH_TOKEN_IPG_EN to hold off new requests for IPG_CYCLES after each packet.
module usbh_token_tx
    import usbh_pkg::*;
#(
    parameter int unsigned IPG_CYCLES = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  pid_i,
    input  logic [10:0] token_i,
    output logic        ready_o,
    output logic        done_o,
    output logic        error_o,
    output logic [7:0]  utmi_data_o,
    output logic        utmi_txvalid_o,
    input  logic        utmi_txready_i
);

    token_state_e state_q, state_d;
    logic [7:0]   pid_q;
    logic [10:0]  token_q;
    logic         done_q, done_d;
    logic         error_q, error_d;
    logic         load;
    logic [4:0]   crcRaw;
    logic [4:0]   crcField;

`ifdef USBH_TOKEN_IPG_EN
    localparam int unsigned CNT_W = (IPG_CYCLES > 0) ? $clog2(IPG_CYCLES + 1) : 1;
    logic [CNT_W-1:0] gapCnt_q, gapCnt_d;
`endif

    usbh_crc5 u_crc5 (
        .crc_i  (CRC5_SEED),
        .data_i (token_q),
        .crc_o  (crcRaw)
    );

    assign crcField = ~crcRaw;
    assign ready_o  = (state_q == TOK_IDLE);
    assign done_o   = done_q;
    assign error_o  = error_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= TOK_IDLE;
            pid_q    <= 8'h00;
            token_q  <= 11'h000;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef USBH_TOKEN_IPG_EN
            gapCnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            error_q  <= error_d;
            if (load) begin
                pid_q   <= pid_i;
                token_q <= token_i;
            end
`ifdef USBH_TOKEN_IPG_EN
            gapCnt_q <= gapCnt_d;
`endif
        end
    end

    // Each byte state holds its byte and valid until the PHY handshakes it.
    always_comb begin
        state_d        = state_q;
        done_d         = 1'b0;
        error_d        = 1'b0;
        load           = 1'b0;
        utmi_txvalid_o = 1'b0;
        utmi_data_o    = 8'h00;
`ifdef USBH_TOKEN_IPG_EN
        gapCnt_d       = gapCnt_q;
`endif
        case (state_q)
            TOK_IDLE: begin
                if (start_i) begin
                    load = 1'b1;
                    if (pidCheckOk(pid_i)) begin
                        state_d = TOK_PID;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            TOK_PID: begin
                utmi_txvalid_o = 1'b1;
                utmi_data_o    = pid_q;
                if (utmi_txready_i) begin
                    state_d = TOK_TOK1;
                end
            end
            TOK_TOK1: begin
                utmi_txvalid_o = 1'b1;
                utmi_data_o    = token_q[7:0];
                if (utmi_txready_i) begin
                    state_d = TOK_TOK2;
                end
            end
            TOK_TOK2: begin
                utmi_txvalid_o = 1'b1;
                utmi_data_o    = {crcField, token_q[10:8]};
                if (utmi_txready_i) begin
                    done_d  = 1'b1;
                    state_d = TOK_IDLE;
`ifdef USBH_TOKEN_IPG_EN
                    if (IPG_CYCLES != 0) begin
                        state_d  = TOK_GAP;
                        gapCnt_d = CNT_W'(IPG_CYCLES - 1);
                    end
`endif
                end
            end
`ifdef USBH_TOKEN_IPG_EN
            // Counter is preloaded with IPG_CYCLES-1 so the gap lasts exactly IPG_CYCLES cycles.
            TOK_GAP: begin
                if (gapCnt_q == '0) begin
                    state_d = TOK_IDLE;
                end else begin
                    gapCnt_d = gapCnt_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = TOK_IDLE;
            end
        endcase
    end

endmodule

// File: doc/usbh_token_tx.md
Name: usbh_token_tx

Overview:
Token packet transmitter for the USB full-speed host. Latches a PID plus an 11-bit token field, which is either {ep[3:0], addr[6:0]} or frame[10:0]. Computes the token CRC5 by instancing the existing 5-bit token CRC block. Serialises the 3-byte packet onto the UTMI transmit byte interface and sits directly upstream of the UTMI PHY, driven by the host SIE sequencer.

Parameters:
IPG_CYCLES, 8, idle cycles held after the last token byte before accepting the next request; used only with the optional feature.

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset; synchronous, active-high
start_i  input  1  request to send one token; sampled only when ready_o=1
pid_i  input  8  full PID byte, {~pid[3:0], pid[3:0]}
token_i  input  11  token field; addr in [6:0] and ep in [10:7], or frame number
ready_o  output  1  block idle, can accept start_i
done_o  output  1  one-cycle pulse: token fully accepted by the PHY
error_o  output  1  one-cycle pulse: start rejected, PID check failed
utmi_data_o  output  8  transmit byte
utmi_txvalid_o  output  1  transmit byte valid
utmi_txready_i  input  1  PHY accepted current byte

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - state=IDLE; ready_o=1.
  - done_o=0, error_o=0, utmi_txvalid_o=0, utmi_data_o=8'h00.
  - Reset mid-packet abandons the packet; txvalid drops the cycle after the reset edge and no done_o is produced.
- Accept: start_i=1 and ready_o=1 at an edge.
  - pid_i and token_i are registered and ready_o falls next cycle.
  - If pid_i[7:4] != ~pid_i[3:0], pulse error_o next cycle, stay IDLE, transmit nothing.
- CRC:
  - crc_i=5'h1F, data_i=token_q, crc field = bitwise inverse of crc_o.
  - Computed combinationally from the registered token; no extra latency.
- Byte order, LSB-first on the wire:
  - B0 = pid_q
  - B1 = token_q[7:0]
  - B2 = {crc[4:0], token_q[10:8]}
- FSM states: IDLE -> PID -> TOK1 -> TOK2 -> (GAP) -> IDLE.
  - PID/TOK1/TOK2 drive utmi_txvalid_o=1 with the corresponding byte.
  - Each state advances only on an edge where utmi_txready_i=1.
  - Byte and valid are held stable while txready is low, with no bound on stall length.
- First byte latency: txvalid asserts the cycle after acceptance.
  - Minimum packet time: 1 accept cycle + 3 transfer cycles with txready tied high.
- Completion: on the TOK2 handshake edge, txvalid deasserts and done_o pulses high for exactly one cycle (the next cycle).
  - Without GAP, ready_o returns high in that same cycle.
  - Back-to-back tokens are then possible with one idle cycle between packets.
- txvalid never deasserts mid-packet except on reset. start_i while busy is ignored, not queued.
- Asserting utmi_txready_i while txvalid=0 has no effect.

Optional Feature:
USBH_TOKEN_IPG_EN.
- Defined: after TOK2 the FSM enters GAP and counts IPG_CYCLES clocks with a down-counter of width clog2(IPG_CYCLES+1).
  - ready_o stays 0 until the counter reaches zero.
  - done_o still pulses on the cycle after the TOK2 handshake.
  - IPG_CYCLES=0 behaves as undefined.
- Undefined: no GAP state, no counter; TOK2 goes directly to IDLE.

Decomposition:
- Shared package usbh_pkg:
  - PID constants: OUT=8'hE1, IN=8'h69, SOF=8'hA5, SETUP=8'h2D.
  - Token FSM state enum.
  - CRC5 seed 5'h1F.
- One sub-module: the existing usbh_crc5, instanced once. No other hierarchy.

Test Plan:
- SETUP, token_i=11'h000, txready tied 1 -> bytes 8'h2D, 8'h00, 8'h10 on three consecutive cycles; done_o single pulse; ready_o high again.
- IN, addr=7'h05, ep=4'h1, txready stalled 3 cycles on each byte -> data and valid held stable through stalls.
  - Bytes 8'h69, 8'h85, {crc,3'b000}, checked against a software CRC5 model.
- pid_i=8'h2C -> error_o pulses once; txvalid stays 0; ready_o stays 1.
- rst_i asserted while TOK1 is stalled -> next cycle txvalid=0, ready_o=1, no done_o; a new SETUP token then transmits correctly.
- Two SOF tokens (frame 11'h000, then 11'h7FF) with start_i held high -> second PID appears exactly 1 cycle after done_o, or IPG_CYCLES+1 cycles with USBH_TOKEN_IPG_EN.
- start_i pulsed while busy -> ignored; exactly one packet is emitted.
